// File: rtl/punc_control.sv
// rtl/punc_control.sv - multi-cycle control FSM for the PUnC LC3 datapath
// Outputs are decoded combinationally from the current state and the held instruction.
module punc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_out,
  input  logic        nzp_match,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        ir_clr,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [1:0]  dmem_r_addr_sel,
  output logic [1:0]  dmem_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        rf_w_wr,
  output logic        rf_rp_addr_sel,
  output logic        rf_rp_rd,
  output logic        rf_rq_rd,
  output logic        temp_ld,
  output logic        nzp_ld,
  output logic        nzp_clr,
  output logic [1:0]  alu_sel,
  output logic        alu_in_a_sel,
  output logic        halted,
  output logic [2:0]  state_debug
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state, next_state;
  logic [3:0] opcode;
  logic       imm_mode;
  logic       jsr_pc_rel;
  logic       unused_ir;

  assign opcode     = ir_out[15:12];
  assign imm_mode   = ir_out[5];
  assign jsr_pc_rel = ir_out[11];
  // Operand fields below are consumed by the datapath, not by control.
  assign unused_ir  = ^{ir_out[10:6], ir_out[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= next_state;
  end

  always_comb begin
    next_state      = state;
    pc_ld           = 1'b0;
    pc_clr          = 1'b0;
    pc_inc          = 1'b0;
    pc_sel          = 2'd0;
    ir_ld           = 1'b0;
    ir_clr          = 1'b0;
    dmem_rd         = 1'b0;
    dmem_wr         = 1'b0;
    dmem_r_addr_sel = 2'd0;
    dmem_w_addr_sel = 2'd0;
    rf_w_data_sel   = 2'd0;
    rf_w_addr_sel   = 1'b0;
    rf_w_wr         = 1'b0;
    rf_rp_addr_sel  = 1'b0;
    rf_rp_rd        = 1'b0;
    rf_rq_rd        = 1'b0;
    temp_ld         = 1'b0;
    nzp_ld          = 1'b0;
    nzp_clr         = 1'b0;
    alu_sel         = 2'd0;
    alu_in_a_sel    = 1'b0;

    case (state)
      S_INIT: begin
        pc_clr     = 1'b1;
        ir_clr     = 1'b1;
        nzp_clr    = 1'b1;
        next_state = S_FETCH;
      end

      S_FETCH: begin
        dmem_r_addr_sel = 2'd0;
        dmem_rd         = 1'b1;
        ir_ld           = 1'b1;
        pc_inc          = 1'b1;
        next_state      = S_DECODE;
      end

      S_DECODE: begin
        next_state = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      end

      S_EXEC: begin
        next_state = ((opcode == OP_LDI) || (opcode == OP_STI)) ? S_EXEC2 : S_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_w_addr_sel = 1'b1;
            rf_w_data_sel = 2'd0;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
            rf_rq_rd      = 1'b1;
            if (opcode == OP_ADD)      alu_sel = 2'd1;
            else if (opcode == OP_AND) alu_sel = 2'd2;
            else                       alu_sel = 2'd3;
            if (imm_mode) begin
              alu_in_a_sel = 1'b1;
            end else begin
              alu_in_a_sel   = 1'b0;
              rf_rp_addr_sel = 1'b1;
              rf_rp_rd       = 1'b1;
            end
          end
          OP_BR: begin
            pc_sel = 2'd0;
            pc_ld  = nzp_match;
          end
          OP_JMP: begin
            pc_sel   = 2'd2;
            pc_ld    = 1'b1;
            rf_rq_rd = 1'b1;
          end
          OP_JSR: begin
            // R7 captures the PC on the same edge the PC is redirected.
            rf_w_addr_sel = 1'b0;
            rf_w_data_sel = 2'd3;
            rf_w_wr       = 1'b1;
            pc_sel        = jsr_pc_rel ? 2'd1 : 2'd2;
            pc_ld         = 1'b1;
          end
          OP_LD: begin
            dmem_r_addr_sel = 2'd1;
            rf_w_data_sel   = 2'd2;
            rf_w_addr_sel   = 1'b1;
            rf_w_wr         = 1'b1;
            nzp_ld          = 1'b1;
          end
          OP_LDR: begin
            dmem_r_addr_sel = 2'd3;
            rf_w_data_sel   = 2'd2;
            rf_w_addr_sel   = 1'b1;
            rf_w_wr         = 1'b1;
            nzp_ld          = 1'b1;
          end
          OP_LEA: begin
            rf_w_data_sel = 2'd1;
            rf_w_addr_sel = 1'b1;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
          end
          OP_ST: begin
            rf_rp_addr_sel  = 1'b0;
            dmem_w_addr_sel = 2'd0;
            dmem_wr         = 1'b1;
          end
          OP_STR: begin
            rf_rp_addr_sel  = 1'b0;
            dmem_w_addr_sel = 2'd2;
            dmem_wr         = 1'b1;
          end
          OP_LDI: begin
            // Pointer lands in the destination register; EXEC2 dereferences it.
            dmem_r_addr_sel = 2'd1;
            rf_w_data_sel   = 2'd2;
            rf_w_addr_sel   = 1'b1;
            rf_w_wr         = 1'b1;
          end
          OP_STI: begin
            dmem_r_addr_sel = 2'd1;
            temp_ld         = 1'b1;
          end
          default: begin
          end
        endcase
      end

      S_EXEC2: begin
        next_state = S_FETCH;
        if (opcode == OP_LDI) begin
          rf_rp_addr_sel  = 1'b0;
          dmem_r_addr_sel = 2'd2;
          rf_w_data_sel   = 2'd2;
          rf_w_addr_sel   = 1'b1;
          rf_w_wr         = 1'b1;
          nzp_ld          = 1'b1;
        end else if (opcode == OP_STI) begin
          rf_rp_addr_sel  = 1'b0;
          dmem_w_addr_sel = 2'd1;
          dmem_wr         = 1'b1;
        end
      end

      S_HALT: begin
        next_state = S_HALT;
      end

      default: begin
        next_state = S_INIT;
      end
    endcase
  end

  assign halted      = (state == S_HALT);
  assign state_debug = state;

endmodule

// File: tb/tb_punc_control.sv
// tb/tb_punc_control.sv - scoreboard bench for punc_control
// Expected per-cycle control words come from an instruction-level model.
module tb_punc_control;

  logic        clk;
  logic        rst;
  logic [15:0] ir_out;
  logic        nzp_match;
  logic        pc_ld, pc_clr, pc_inc;
  logic [1:0]  pc_sel;
  logic        ir_ld, ir_clr, dmem_rd, dmem_wr;
  logic [1:0]  dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel;
  logic        rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
  logic        temp_ld, nzp_ld, nzp_clr;
  logic [1:0]  alu_sel;
  logic        alu_in_a_sel, halted;
  logic [2:0]  state_debug;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       ir_clr;
    logic       dmem_rd;
    logic       dmem_wr;
    logic [1:0] dmem_r_addr_sel;
    logic [1:0] dmem_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       rf_w_wr;
    logic       rf_rp_addr_sel;
    logic       rf_rp_rd;
    logic       rf_rq_rd;
    logic       temp_ld;
    logic       nzp_ld;
    logic       nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_in_a_sel;
    logic       halted;
    logic [2:0] state_debug;
  } ctl_t;

  ctl_t act;
  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  punc_control dut (
    .clk(clk), .rst(rst), .ir_out(ir_out), .nzp_match(nzp_match),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_r_addr_sel(dmem_r_addr_sel), .dmem_w_addr_sel(dmem_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
    .rf_rp_addr_sel(rf_rp_addr_sel), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd),
    .temp_ld(temp_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
    .alu_in_a_sel(alu_in_a_sel), .halted(halted), .state_debug(state_debug)
  );

  assign act = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
                dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
                rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
                alu_sel, alu_in_a_sel, halted, state_debug};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t blank(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.state_debug = st;
    return c;
  endfunction

  function automatic ctl_t init_v();
    ctl_t c = blank(3'd0);
    c.pc_clr = 1'b1; c.ir_clr = 1'b1; c.nzp_clr = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch_v();
    ctl_t c = blank(3'd1);
    c.dmem_rd = 1'b1; c.ir_ld = 1'b1; c.pc_inc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t halt_v();
    ctl_t c = blank(3'd5);
    c.halted = 1'b1;
    return c;
  endfunction

  // Register writeback to ir[11:9] with the given data source.
  function automatic ctl_t wr_dest(input ctl_t c0, input logic [1:0] src, input logic set_cc);
    ctl_t c = c0;
    c.rf_w_addr_sel = 1'b1; c.rf_w_wr = 1'b1; c.rf_w_data_sel = src; c.nzp_ld = set_cc;
    return c;
  endfunction

  function automatic ctl_t exec_v(input logic [15:0] ir, input logic m);
    ctl_t c = blank(3'd3);
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: begin
        c = wr_dest(c, 2'd0, 1'b1);
        c.rf_rq_rd = 1'b1;
        c.alu_sel = (ir[15:12] == 4'h1) ? 2'd1 : (ir[15:12] == 4'h5) ? 2'd2 : 2'd3;
        if (ir[5]) c.alu_in_a_sel = 1'b1;
        else begin c.rf_rp_addr_sel = 1'b1; c.rf_rp_rd = 1'b1; end
      end
      4'h0: c.pc_ld = m;
      4'hC: begin c.pc_sel = 2'd2; c.pc_ld = 1'b1; c.rf_rq_rd = 1'b1; end
      4'h4: begin
        c.rf_w_data_sel = 2'd3; c.rf_w_wr = 1'b1; c.pc_ld = 1'b1;
        c.pc_sel = ir[11] ? 2'd1 : 2'd2;
      end
      4'h2: begin c = wr_dest(c, 2'd2, 1'b1); c.dmem_r_addr_sel = 2'd1; end
      4'h6: begin c = wr_dest(c, 2'd2, 1'b1); c.dmem_r_addr_sel = 2'd3; end
      4'hE: c = wr_dest(c, 2'd1, 1'b1);
      4'h3: c.dmem_wr = 1'b1;
      4'h7: begin c.dmem_wr = 1'b1; c.dmem_w_addr_sel = 2'd2; end
      4'hA: begin c = wr_dest(c, 2'd2, 1'b0); c.dmem_r_addr_sel = 2'd1; end
      4'hB: begin c.dmem_r_addr_sel = 2'd1; c.temp_ld = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t exec2_v(input logic [15:0] ir);
    ctl_t c = blank(3'd4);
    if (ir[15:12] == 4'hA) begin
      c = wr_dest(c, 2'd2, 1'b1);
      c.dmem_r_addr_sel = 2'd2;
    end else begin
      c.dmem_w_addr_sel = 2'd1; c.dmem_wr = 1'b1;
    end
    return c;
  endfunction

  task automatic chk(input string name, input ctl_t got, input ctl_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor_underflow: got state %0d expected nothing queued (t=%0t)",
                 state_debug, $time);
      end else begin
        ctl_t e;
        e = exp_q.pop_front();
        chk("cycle", act, e);
      end
    end
  end

  // Called at posedge+1 while the DUT is in FETCH.
  task automatic run_instr(input logic [15:0] ir, input logic m);
    int n;
    ir_out = ir;
    nzp_match = m;
    exp_q.push_back(fetch_v());
    exp_q.push_back(blank(3'd2));
    exp_q.push_back(exec_v(ir, m));
    n = 3;
    if (ir[15:12] == 4'hA || ir[15:12] == 4'hB) begin
      exp_q.push_back(exec2_v(ir));
      n = 4;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_async", act, init_v());
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_hold", act, init_v());
    rst = 1'b1;
    exp_q.push_back(init_v());
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ir;
    rst = 1'b0;
    ir_out = 16'h0000;
    nzp_match = 1'b0;
    #2;
    chk("reset_state", act, init_v());
    @(posedge clk);
    #1;
    do_reset();

    run_instr(16'h1225, 1'b0);
    run_instr(16'h0403, 1'b1);
    run_instr(16'h0403, 1'b0);
    run_instr(16'h4810, 1'b0);
    run_instr(16'hC1C0, 1'b0);
    run_instr(16'h4080, 1'b1);
    run_instr(16'h927F, 1'b0);
    run_instr(16'h5042, 1'b0);
    run_instr(16'hA401, 1'b0);
    run_instr(16'hB601, 1'b1);
    run_instr(16'h8000, 1'b1);
    run_instr(16'hD123, 1'b0);

    for (int i = 0; i < 80; i++) begin
      ir = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ir, 1'($urandom_range(0, 1)));
    end

    // HALT parks the machine for 20 cycles until reset.
    ir_out = 16'hF025;
    exp_q.push_back(fetch_v());
    exp_q.push_back(blank(3'd2));
    for (int i = 0; i < 20; i++) exp_q.push_back(halt_v());
    repeat (22) @(posedge clk);
    #1;
    do_reset();

    run_instr(16'h1021, 1'b0);

    // Reset dropped mid-EXEC of ST must kill the write immediately.
    ir_out = 16'h3205;
    exp_q.push_back(fetch_v());
    exp_q.push_back(blank(3'd2));
    repeat (2) @(posedge clk);
    #1;
    chk("st_exec", act, exec_v(16'h3205, 1'b0));
    do_reset();

    run_instr(16'h6283, 1'b0);
    run_instr(16'hE5FF, 1'b0);

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
